// File: rtl/cam_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cam_stream_pkg
//  Description : Shared types and constants for the parallel camera-bus
//                test-pattern transmitter (FSM states, pattern codes,
//                RGB565 bar colours, stripe band height).
//  Revision    : 1.0 - initial release
// ============================================================================
package cam_stream_pkg;

    // Transmitter frame/line sequencing states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBP    = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_HBLANK = 3'd4,
        ST_VFP    = 3'd5
    } cam_state_t;

    // PATTERN_SEL encodings
    localparam logic [1:0] PAT_SOLID  = 2'd0;
    localparam logic [1:0] PAT_BARS   = 2'd1;
    localparam logic [1:0] PAT_STRIPE = 2'd2;
    localparam logic [1:0] PAT_GRAD   = 2'd3;

    // RGB565 colour-bar palette, left to right
    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    // Rows per stripe band; the stripe shifts by SLOPE once per band
    localparam int STRIPE_BAND = 12;

endpackage
`default_nettype wire

// File: rtl/cam_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : cam_pattern_gen
//  Description : Combinational RGB565 pixel function of (x, row) and the
//                frame-latched pattern controls.
//  Revision    : 1.0 - initial release
// ============================================================================
module cam_pattern_gen
    import cam_stream_pkg::*;
#(
    parameter int WIDTH = 176
) (
    input  logic [7:0]  i_x,
    input  logic [7:0]  i_row,
    input  logic [1:0]  i_pat_sel,
    input  logic [15:0] i_color,
    input  logic [7:0]  i_line_x,
    input  logic [2:0]  i_slope,
    output logic [15:0] o_pix
);

    localparam logic [7:0] c_BAR_W     = 8'(WIDTH / 8);
    localparam logic [7:0] c_BAND      = 8'(STRIPE_BAND);
    localparam logic [9:0] c_START_MAX = 10'(WIDTH - 4);

    logic [7:0]  w_bar;
    logic [15:0] w_bar_pix;
    logic [9:0]  w_band;
    logic [9:0]  w_slope;
    logic [9:0]  w_start_raw;
    logic [9:0]  w_start;
    logic [9:0]  w_x;
    logic        w_in_stripe;

    // Colour bars: eight equal-width bars selected by column
    always_comb begin
        w_bar = i_x / c_BAR_W;
        case (w_bar)
            8'd0:    w_bar_pix = RGB_WHITE;
            8'd1:    w_bar_pix = RGB_YELLOW;
            8'd2:    w_bar_pix = RGB_CYAN;
            8'd3:    w_bar_pix = RGB_GREEN;
            8'd4:    w_bar_pix = RGB_MAGENTA;
            8'd5:    w_bar_pix = RGB_RED;
            8'd6:    w_bar_pix = RGB_BLUE;
            default: w_bar_pix = RGB_BLACK;
        endcase
    end

    // Slanted stripe: 10-bit two's-complement start, clamped so all four
    // stripe columns stay on the line
    always_comb begin
        w_band      = {2'b00, i_row / c_BAND};
        w_slope     = {{7{i_slope[2]}}, i_slope};
        w_start_raw = {2'b00, i_line_x} + w_slope * w_band;
        if (w_start_raw[9]) begin
            w_start = 10'd0;
        end else if (w_start_raw > c_START_MAX) begin
            w_start = c_START_MAX;
        end else begin
            w_start = w_start_raw;
        end
        w_x         = {2'b00, i_x};
        w_in_stripe = (w_x >= w_start) && (w_x < w_start + 10'd4);
    end

    // Final pattern select
    always_comb begin
        case (i_pat_sel)
            PAT_SOLID:  o_pix = i_color;
            PAT_BARS:   o_pix = w_bar_pix;
            PAT_STRIPE: o_pix = w_in_stripe ? 16'hFFFF : 16'h0000;
            default:    o_pix = {i_x[7:3], i_row[7:2], i_x[4:0] ^ i_row[4:0]};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cam_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : cam_stream_gen
//  Description : OV7670-style parallel pixel-bus transmitter (PCLK, VSYNC,
//                HREF, 8-bit DATA, RGB565 low byte first) producing
//                continuous test frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module cam_stream_gen
    import cam_stream_pkg::*;
#(
    parameter int WIDTH     = 176,
    parameter int HEIGHT    = 144,
    parameter int VS_LINES  = 3,
    parameter int VBP_LINES = 17,
    parameter int VFP_LINES = 10,
    parameter int H_BLANK   = 144
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic [1:0]  PATTERN_SEL,
    input  logic [15:0] COLOR,
    input  logic [7:0]  LINE_X,
    input  logic [2:0]  SLOPE,
    output logic        PCLK_OUT,
    output logic        VSYNC,
    output logic        HREF,
    output logic [7:0]  DATA,
    output logic        FRAME_DONE
);

    localparam int c_ACT_BYTES  = 2 * WIDTH;
    localparam int c_LINE_BYTES = c_ACT_BYTES + H_BLANK;
    localparam int c_BW         = $clog2(c_LINE_BYTES);
    localparam int c_VMAX0      = (VS_LINES > VBP_LINES) ? VS_LINES : VBP_LINES;
    localparam int c_VMAX       = (c_VMAX0 > VFP_LINES) ? c_VMAX0 : VFP_LINES;
    localparam int c_LW         = (c_VMAX > 1) ? $clog2(c_VMAX) : 1;
    localparam int c_RW         = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [c_BW-1:0] c_BYTE_LAST = c_BW'(c_LINE_BYTES - 1);
    localparam logic [c_BW-1:0] c_ACT_LAST  = c_BW'(c_ACT_BYTES - 1);
    localparam logic [c_BW-1:0] c_HB_FIRST  = c_BW'(c_ACT_BYTES);
    localparam logic [c_LW-1:0] c_VS_LAST   = c_LW'(VS_LINES - 1);
    localparam logic [c_LW-1:0] c_VBP_LAST  = c_LW'(VBP_LINES - 1);
    localparam logic [c_LW-1:0] c_VFP_LAST  = c_LW'(VFP_LINES - 1);
    localparam logic [c_RW-1:0] c_ROW_LAST  = c_RW'(HEIGHT - 1);

    cam_state_t      r_state, w_state_nxt;
    logic            r_phase;
    logic [c_BW-1:0] r_bcnt, w_bcnt_nxt, w_bcnt_step;
    logic [c_LW-1:0] r_lcnt, w_lcnt_nxt;
    logic [c_RW-1:0] r_row, w_row_nxt;
    logic            w_line_end;
    logic            w_latch;

    logic [1:0]      r_pat_sel;
    logic [15:0]     r_color;
    logic [7:0]      r_line_x;
    logic [2:0]      r_slope;
    logic [15:0]     w_pix;

    // State, byte/line/row counters and the PCLK phase
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_phase <= 1'b0;
            r_state <= ST_IDLE;
            r_bcnt  <= '0;
            r_lcnt  <= '0;
            r_row   <= '0;
        end else begin
            r_phase <= ~r_phase;
            r_state <= w_state_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_lcnt  <= w_lcnt_nxt;
            r_row   <= w_row_nxt;
        end
    end

    // Pattern controls captured only when a frame enters VSYNC
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_pat_sel <= '0;
            r_color   <= '0;
            r_line_x  <= '0;
            r_slope   <= '0;
        end else if (w_latch) begin
            r_pat_sel <= PATTERN_SEL;
            r_color   <= COLOR;
            r_line_x  <= LINE_X;
            r_slope   <= SLOPE;
        end
    end

    assign w_line_end  = (r_bcnt == c_BYTE_LAST);
    assign w_bcnt_step = w_line_end ? '0 : r_bcnt + c_BW'(1);

    // Next state: everything advances only at the phase-1 -> phase-0 boundary
    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
        w_lcnt_nxt  = r_lcnt;
        w_row_nxt   = r_row;
        w_latch     = 1'b0;
        if (r_phase) begin
            case (r_state)
                ST_IDLE: begin
                    if (ENABLE) begin
                        w_state_nxt = ST_VSYNC;
                        w_bcnt_nxt  = '0;
                        w_lcnt_nxt  = '0;
                        w_latch     = 1'b1;
                    end
                end
                ST_VSYNC: begin
                    w_bcnt_nxt = w_bcnt_step;
                    if (w_line_end) begin
                        if (r_lcnt == c_VS_LAST) begin
                            w_state_nxt = ST_VBP;
                            w_lcnt_nxt  = '0;
                        end else begin
                            w_lcnt_nxt = r_lcnt + c_LW'(1);
                        end
                    end
                end
                ST_VBP: begin
                    w_bcnt_nxt = w_bcnt_step;
                    if (w_line_end) begin
                        if (r_lcnt == c_VBP_LAST) begin
                            w_state_nxt = ST_ACTIVE;
                            w_lcnt_nxt  = '0;
                            w_row_nxt   = '0;
                        end else begin
                            w_lcnt_nxt = r_lcnt + c_LW'(1);
                        end
                    end
                end
                ST_ACTIVE: begin
                    w_bcnt_nxt = w_bcnt_step;
                    if (r_bcnt == c_ACT_LAST) begin
                        w_state_nxt = ST_HBLANK;
                    end
                end
                ST_HBLANK: begin
                    w_bcnt_nxt = w_bcnt_step;
                    if (w_line_end) begin
                        if (r_row == c_ROW_LAST) begin
                            w_state_nxt = ST_VFP;
                            w_lcnt_nxt  = '0;
                        end else begin
                            w_state_nxt = ST_ACTIVE;
                            w_row_nxt   = r_row + c_RW'(1);
                        end
                    end
                end
                ST_VFP: begin
                    w_bcnt_nxt = w_bcnt_step;
                    if (w_line_end) begin
                        if (r_lcnt == c_VFP_LAST) begin
                            w_lcnt_nxt = '0;
                            if (ENABLE) begin
                                w_state_nxt = ST_VSYNC;
                                w_latch     = 1'b1;
                            end else begin
                                w_state_nxt = ST_IDLE;
                            end
                        end else begin
                            w_lcnt_nxt = r_lcnt + c_LW'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_bcnt_nxt  = '0;
                    w_lcnt_nxt  = '0;
                    w_row_nxt   = '0;
                end
            endcase
        end
    end

    cam_pattern_gen #(
        .WIDTH (WIDTH)
    ) u_pattern (
        .i_x       (8'(r_bcnt >> 1)),
        .i_row     (8'(r_row)),
        .i_pat_sel (r_pat_sel),
        .i_color   (r_color),
        .i_line_x  (r_line_x),
        .i_slope   (r_slope),
        .o_pix     (w_pix)
    );

    // Bus outputs decode registered state, so they only move at phase 0
    always_comb begin
        PCLK_OUT   = r_phase;
        VSYNC      = (r_state == ST_VSYNC);
        HREF       = (r_state == ST_ACTIVE);
        DATA       = (r_state == ST_ACTIVE) ? (r_bcnt[0] ? w_pix[15:8] : w_pix[7:0]) : 8'h00;
        FRAME_DONE = (r_state == ST_HBLANK) && (r_bcnt == c_HB_FIRST) &&
                     (r_row == c_ROW_LAST) && !r_phase;
    end

endmodule
`default_nettype wire

// File: doc/cam_stream_gen.md
# cam_stream_gen

Synthesizable transmitter for the OV7670-style parallel pixel bus: PCLK, VSYNC, HREF and 8-bit data, two bytes per RGB565 pixel, low byte first. It generates QCIF (176x144) test frames with known content, so the downsampler and line/colour classifier can be driven and checked on the board and in simulation without a camera. It sits on the FPGA and is muxed in place of the GPIO_1 camera inputs.

## Interface
Parameters:
- WIDTH, 176, active pixels per line
- HEIGHT, 144, active lines per frame
- VS_LINES, 3, line-times with VSYNC high
- VBP_LINES, 17, blank line-times after VSYNC, before the first active line
- VFP_LINES, 10, blank line-times after the last active line
- H_BLANK, 144, byte-times with HREF low after each active line

Ports (one clock; reset is synchronous and active-high):
- CLOCK  in  1  system clock, 2x the generated PCLK
- RESET  in  1  synchronous active-high reset
- ENABLE  in  1  run frames continuously while high
- PATTERN_SEL  in  2  0 solid, 1 colour bars, 2 slanted stripe, 3 gradient
- COLOR  in  16  RGB565 colour for the solid pattern
- LINE_X  in  8  stripe start column on rows 0..11
- SLOPE  in  3  signed stripe shift per 12-row band
- PCLK_OUT  out  1  pixel clock
- VSYNC  out  1  frame sync, active high
- HREF  out  1  line valid, active high
- DATA  out  8  pixel byte
- FRAME_DONE  out  1  one-cycle pulse at the end of the last active byte of a frame

## Operation
- **Byte-time:** two CLOCK cycles.
  - Phase 0: PCLK_OUT = 0. DATA and HREF update.
  - Phase 1: PCLK_OUT = 1. DATA and HREF are held.
  - PCLK_OUT toggles every cycle whenever RESET is low, including in IDLE.
- **Line-time:** 2*WIDTH + H_BLANK byte-times (496 with the defaults).
- **FSM states:**
  - IDLE: VSYNC, HREF and DATA are 0. Go to VSYNC at a phase-0 boundary when ENABLE = 1.
  - VSYNC: VSYNC = 1 for VS_LINES line-times. Go to VBP.
  - VBP: blank for VBP_LINES line-times. Go to ACTIVE with row = 0.
  - ACTIVE: HREF = 1 for 2*WIDTH byte-times. Go to HBLANK.
  - HBLANK: H_BLANK byte-times. Then go to ACTIVE with row+1, or to VFP if row == HEIGHT-1.
  - VFP: VFP_LINES line-times. Then go to VSYNC if ENABLE = 1, else IDLE.
- **ENABLE deassert mid-frame:** the current frame completes, including VFP, before IDLE.
- **Latching:** PATTERN_SEL, COLOR, LINE_X and SLOPE are latched on entry to VSYNC. Changes mid-frame are ignored.
- **Byte order:** pixel (x, row) is sent as byte 2x = pix[7:0], then byte 2x+1 = pix[15:8].
- **Patterns:**
  - 0 solid: pix = COLOR.
  - 1 bars: 8 bars of WIDTH/8 columns, in the order white, yellow, cyan, green, magenta, red, blue, black.
  - 2 stripe:
    - Stripe start = LINE_X + SLOPE*(row/12), computed in 10-bit signed and clamped to [0, WIDTH-4].
    - Columns start..start+3 are 16'hFFFF; all others are 16'h0000.
  - 3 gradient: pix = {x[7:3], row[7:2], x[4:0]^row[4:0]}.
- **DATA outside ACTIVE:** 8'h00.

## Timing
- Reset values (next CLOCK edge after RESET high): PCLK_OUT 0, VSYNC 0, HREF 0, DATA 0, FRAME_DONE 0, state IDLE, all counters 0.
- RESET mid-line or mid-frame aborts immediately. The next frame starts from VSYNC once RESET is low and ENABLE is high.
- HREF rises in the same cycle as the phase 0 of byte 0. HREF falls in the phase 0 after byte 2*WIDTH-1.
- FRAME_DONE is high for exactly one cycle: the first phase 0 of the HBLANK after row HEIGHT-1.
- Frame period with defaults: 174 line-times = 172,608 CLOCK cycles.
- The pixel function is combinational from registered x/row. Adding a register stage is allowed if the computation is started one byte-time early, so that DATA alignment to HREF is unchanged.
- Counters:
  - Byte counter wraps at line-time-1.
  - Line counter wraps per state length.
  - Widths come from $clog2 of the parameters.

## Structure
- Package cam_stream_pkg holds:
  - the state enum;
  - the PAT_SOLID, PAT_BARS, PAT_STRIPE and PAT_GRAD codes;
  - the RGB565 bar colour constants;
  - STRIPE_BAND = 12.
- Sub-module cam_pattern_gen is the combinational pixel function: (x, row, latched controls) -> 16-bit pix.
- The FSM and counters live in the top module.

## Test plan
- **Solid:** PATTERN_SEL=0, COLOR=16'hF800 -> each HREF pulse carries 352 bytes alternating 8'h00, 8'hF8; 144 HREF pulses per frame; VSYNC high for 2976 cycles.
- **Stripe:** PATTERN_SEL=2, LINE_X=40, SLOPE=+2 -> rows 0..11 are white at x 40..43 and rows 12..23 at x 42..45. With SLOPE=-4 and LINE_X=10, rows 36..47 clamp to x 0..3.
- **PCLK protocol:** on every PCLK_OUT rising edge, DATA and HREF are equal to their values on the preceding CLOCK edge. A PCLK_OUT edge occurs every cycle during blanking.
- **ENABLE deassert:** drop ENABLE at row 50 -> rows 50..143 are still sent, FRAME_DONE pulses once, then IDLE with VSYNC = HREF = 0 and no new VSYNC.
- **Reset mid-line:** RESET at byte 100 of row 7 -> the next cycle shows all outputs 0. After release with ENABLE = 1, VSYNC rises at the next phase-0 boundary.
- **Mid-frame latch:** change PATTERN_SEL mid-frame -> the current frame is unchanged and the new pattern appears from the next frame's row 0.
